// File: rtl/simple_cpu_pkg.sv
// ============================================================================
// Module : simple_cpu_pkg
// Brief  : Shared types and instruction field positions for simple_cpu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package simple_cpu_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_EXECUTE   = 2'd1,
        ST_WRITEBACK = 2'd2
    } state_t;

    localparam logic FUNCT_ADD = 1'b0;
    localparam logic FUNCT_SUB = 1'b1;

    localparam int OPC_HI   = 19;
    localparam int OPC_LO   = 18;
    localparam int X1_HI    = 17;
    localparam int X1_LO    = 16;
    localparam int X2_HI    = 15;
    localparam int X2_LO    = 14;
    localparam int X3_HI    = 13;
    localparam int X3_LO    = 12;
    localparam int OFF_HI   = 11;
    localparam int OFF_LO   = 4;
    localparam int FUNCT_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/simple_cpu_alu.sv
// ============================================================================
// Module : simple_cpu_alu
// Brief  : Combinational modulo-2^DATA_WIDTH add/subtract.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module simple_cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  funct,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = (funct == FUNCT_SUB) ? (a - b) : (a + b);
    end

endmodule

`default_nettype wire

// File: rtl/simple_cpu.sv
// ============================================================================
// Module : simple_cpu
// Brief  : Three-cycle FETCH/EXECUTE/WRITEBACK load/store core with 4-entry
//          register file and internal data memory. SIMPLE_CPU_MEM_CLEAR_EN
//          makes reset clear the data memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module simple_cpu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int INSTR_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   done
);

    localparam int MEM_DEPTH = 1 << ADDR_BITS;

    state_t                 state;
    logic [INSTR_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0]  regs [4];
    logic [DATA_WIDTH-1:0]  mem  [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]  result;
    logic [ADDR_BITS-1:0]   addr;
    logic [DATA_WIDTH-1:0]  store_data;

    opcode_t               opcode;
    logic [1:0]            x1;
    logic [1:0]            x2;
    logic [1:0]            x3;
    logic [7:0]            offset;
    logic                  funct;
    logic [DATA_WIDTH-1:0] alu_y;
    logic                  mem_we;
    logic                  unused_ir_bits;

    assign opcode = opcode_t'(ir[OPC_HI:OPC_LO]);
    assign x1     = ir[X1_HI:X1_LO];
    assign x2     = ir[X2_HI:X2_LO];
    assign x3     = ir[X3_HI:X3_LO];
    assign offset = ir[OFF_HI:OFF_LO];
    assign funct  = ir[FUNCT_BIT];
    assign unused_ir_bits = ^ir[3:1];

    assign mem_we = (state == ST_WRITEBACK) && (opcode == OP_STORE);

    simple_cpu_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a     (regs[x2]),
        .b     (regs[x3]),
        .funct (funct),
        .y     (alu_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_FETCH;
            ir         <= '0;
            done       <= 1'b0;
            result     <= '0;
            addr       <= '0;
            store_data <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= DATA_WIDTH'(i);
            end
        end else begin
            done <= (state == ST_EXECUTE);
            case (state)
                ST_FETCH: begin
                    ir    <= instruction;
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    result     <= alu_y;
                    addr       <= ADDR_BITS'(regs[x2] + DATA_WIDTH'(offset));
                    store_data <= regs[x1];
                    state      <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    // Loads read memory combinationally from the registered address.
                    if (opcode == OP_ALU) begin
                        regs[x1] <= result;
                    end else if (opcode == OP_LOAD) begin
                        regs[x1] <= mem[addr];
                    end
                    state <= ST_FETCH;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef SIMPLE_CPU_MEM_CLEAR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr] <= store_data;
        end
    end
`else
    // Reset forces state to FETCH, so mem_we is already low while rst is held.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= store_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_simple_cpu.sv
// ============================================================================
// Module : tb_simple_cpu
// Brief  : Directed, table-driven bench for simple_cpu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_simple_cpu;
    import simple_cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [19:0] instruction;
    logic        done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [19:0] instr;
        int          is_mem;
        int          idx;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [10];
    int   nvec;

    simple_cpu #(
        .DATA_WIDTH  (8),
        .ADDR_BITS   (5),
        .INSTR_WIDTH (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Enter on a negedge; leaves rst high at a negedge so the next edge is FETCH.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one instruction for three edges, checking the done/state cadence.
    task automatic exec(input logic [19:0] ins);
        instruction = ins;
        @(posedge clk); #1;
        check("state_after_fetch", 8'(dut.state), 8'(ST_EXECUTE));
        check("done_execute", 8'(done), 8'd0);
        @(posedge clk); #1;
        check("done_writeback", 8'(done), 8'd1);
        @(posedge clk); #1;
        check("done_fetch", 8'(done), 8'd0);
    endtask

    initial begin
        nvec = 0;
        vecs[nvec++] = '{20'h47000, 0, 0, 8'd4};
        vecs[nvec++] = '{20'h53000, 0, 1, 8'd7};
        vecs[nvec++] = '{20'h72001, 0, 3, 8'd2};
        vecs[nvec++] = '{20'hD80F0, 1, 17, 8'd7};
        vecs[nvec++] = '{20'hCC160, 1, 24, 8'd4};
        vecs[nvec++] = '{20'hB80F0, 0, 3, 8'd7};
`ifdef SIMPLE_CPU_MEM_CLEAR_EN
        vecs[nvec++] = '{20'hAC160, 0, 2, 8'd0};
`else
        // Seed mem[29] = r0 (4) via mem[r2+27] so the wrapped load is defined.
        vecs[nvec++] = '{20'hC81B0, 1, 29, 8'd4};
        vecs[nvec++] = '{20'hAC160, 0, 2, 8'd4};
`endif

        rst         = 1'b0;
        instruction = '0;
        #12;
        check("rst_r0", dut.regs[0], 8'd0);
        check("rst_r1", dut.regs[1], 8'd1);
        check("rst_r2", dut.regs[2], 8'd2);
        check("rst_r3", dut.regs[3], 8'd3);
        check("rst_done", 8'(done), 8'd0);
        check("rst_state", 8'(dut.state), 8'(ST_FETCH));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            exec(vecs[i].instr);
            if (vecs[i].is_mem != 0)
                check($sformatf("vec%0d_mem%0d", i, vecs[i].idx), dut.mem[vecs[i].idx], vecs[i].exp);
            else
                check($sformatf("vec%0d_r%0d", i, vecs[i].idx), dut.regs[vecs[i].idx], vecs[i].exp);
        end
        check("seq_r0", dut.regs[0], 8'd4);
        check("seq_r1", dut.regs[1], 8'd7);

        // Subtraction wrap-around from reset values.
        do_reset();
        exec(20'h43001);
        check("sub_wrap_r0", dut.regs[0], 8'hFD);

        // Instruction change after FETCH must not affect the in-flight op.
        do_reset();
        instruction = 20'h47000;
        @(posedge clk); #1;
        instruction = 20'h43001;
        @(posedge clk); #1;
        check("late_chg_done", 8'(done), 8'd1);
        @(posedge clk); #1;
        check("late_chg_r0", dut.regs[0], 8'd4);
        exec(20'h43001);
        check("next_fetch_r0", dut.regs[0], 8'd1);

        // Reset during EXECUTE discards the pending write.
        do_reset();
        instruction = 20'h47000;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_state", 8'(dut.state), 8'(ST_FETCH));
        check("midrst_done0", 8'(done), 8'd0);
        @(posedge clk); #1;
        check("midrst_done1", 8'(done), 8'd0);
        @(posedge clk); #1;
        check("midrst_done2", 8'(done), 8'd0);
        check("midrst_r0", dut.regs[0], 8'd0);
        @(negedge clk);
        rst = 1'b1;
        exec(20'h47000);
        check("resume_r0", dut.regs[0], 8'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
